shift_register_ctrl: RTL and testbench
======================================

Name: shift_register_ctrl

Overview:
- Sequencer for the board's serial-in/parallel-out shift-register chain (74HC595-style).
- Accepts one parallel word of NUM_BYTES bytes over a valid/ready handshake.
- Serialises the word MSB-first on sr_data with a divided shift clock sr_clk, then issues one sr_latch pulse so the chain's outputs update together.
- Sits between the display/IO logic and the off-chip shift registers. All shift/latch timing is generated from sysclk.

Parameters:
- NUM_BYTES, 2, number of 8-bit registers in the chain; N_BITS = 8*NUM_BYTES.
- CLK_DIV, 4, sysclk cycles per sr_clk half-period; must be >= 1.
- LATCH_CYCLES, 2, sysclk cycles sr_latch is held high; must be >= 1.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  controller idle; a word is accepted when load_valid && load_ready at a sysclk edge.
- load_data  in  N_BITS  word to shift; bit N_BITS-1 is shifted first.
- sr_clk  out  1  shift clock to the chain.
- sr_data  out  1  serial data to the chain.
- sr_latch  out  1  storage-register latch pulse.
- busy  out  1  high from the accept edge until back in IDLE.
- done  out  1  one-cycle pulse on the cycle LATCH exits to IDLE.

Behaviour:
- Reset (reset=1 at an edge):
  - state=IDLE; sr_clk=0, sr_data=0, sr_latch=0, busy=0, done=0.
  - Shift register and counters cleared.
  - load_ready=0 while reset is high, 1 on the first cycle after release.
- All outputs except load_ready are registered. load_ready = (state==IDLE) && !reset.
- States: IDLE, SETUP, HIGH, LATCH.
- IDLE:
  - sr_clk=0, sr_data=0, sr_latch=0.
  - On accept: capture load_data into an internal shifter, bit_cnt=N_BITS-1, half_cnt=CLK_DIV-1, go to SETUP.
- SETUP:
  - sr_clk=0; sr_data=current MSB of the shifter. Hold for CLK_DIV cycles (half_cnt counts down to 0).
  - Then go to HIGH and reload half_cnt.
- HIGH:
  - sr_clk=1; sr_data unchanged. Hold for CLK_DIV cycles.
  - At half_cnt==0:
    - If bit_cnt==0: go to LATCH; sr_clk=0, sr_data=0, sr_latch=1, latch counter loaded with LATCH_CYCLES-1.
    - Else: shift left by 1, decrement bit_cnt, go to SETUP.
- LATCH:
  - sr_latch=1 for exactly LATCH_CYCLES cycles, then go to IDLE; sr_latch=0 and done=1 for one cycle.
- Timing guarantees:
  - sr_data is stable for the full CLK_DIV cycles before every sr_clk rise.
  - sr_data holds through sr_clk high.
  - sr_latch never overlaps sr_clk=1.
- Timing:
  - First cycle with sr_clk=1 is accept edge + CLK_DIV + 1.
  - Exactly N_BITS rising edges of sr_clk per word.
  - busy lasts 2*CLK_DIV*N_BITS + LATCH_CYCLES cycles (defaults: 130).
  - Next accept is possible on the cycle done is high.
- Handshake:
  - load_valid while not IDLE is ignored; the word is neither captured nor queued.
  - load_data is sampled only at the accept edge; later changes have no effect.
- Reset mid-operation: abort on the next edge to IDLE with all outputs low. No latch pulse and no done pulse are issued.
- Counter widths:
  - bit_cnt: clog2(N_BITS).
  - half_cnt: clog2(CLK_DIV), minimum 1 bit.
  - latch counter: clog2(LATCH_CYCLES), minimum 1 bit.
  - No counter may wrap; all decrement to 0 and reload.
- CLK_DIV=1 gives sr_clk = sysclk/2.

Decomposition:
- Package shift_register_pkg:
  - State encoding for IDLE/SETUP/HIGH/LATCH.
  - Default constants SR_NUM_BYTES=2, SR_CLK_DIV=4, SR_LATCH_CYCLES=2.
  - A clog2-based width helper.
- One sub-module, sr_half_period_timer: a loadable down-counter with parameter WIDTH.
  - Inputs: load, load_value, enable.
  - Output: expired, high when count==0 and enable.
  - Instantiated once for the half-period and reused for the latch hold.

Test Plan:
- Reset then idle, defaults: hold reset 3 cycles, release -> all outputs 0 during reset; load_ready=1 on first cycle after release.
- Single word 16'hA5C3, defaults:
  - Accept at cycle 0 -> 16 sr_clk rises at cycles 5, 13, ..., 125; sampled bits 1010_0101_1100_0011.
  - sr_latch high cycles 129-130; done at cycle 131; busy=130 cycles.
- Back-to-back: hold load_valid=1 with 16'hFFFF then 16'h0001 -> second word accepted on the done cycle; second word sampled as 15 zeros then 1.
- Ignored load while busy: pulse load_valid with 16'h1234 at cycle 40 of a 16'h0F0F transfer -> shifted data is 16'h0F0F only; load_ready stays 0 until done.
- Reset mid-shift: assert reset at cycle 60 of a transfer -> next edge sr_clk=0, sr_data=0, sr_latch never asserted, done never pulses.
- Corners, NUM_BYTES=1, CLK_DIV=1, LATCH_CYCLES=1:
  - Word 8'h81 -> sr_clk period 2 cycles, 8 rises, bits 1000_0001.
  - sr_latch high 1 cycle; busy=17 cycles.

Source files
------------

// File: rtl/shift_register_pkg.sv
// -----------------------------------------------------------------------------
// shift_register_pkg
//   Shared definitions for the shift-register chain sequencer:
//     - sr_state_t    : FSM state encoding (IDLE / SETUP / HIGH / LATCH)
//     - SR_*          : default chain geometry and timing constants
//     - sr_cnt_width  : counter width helper (clog2 with a 1-bit floor)
//     - sr_max        : larger of two integers, used to size shared counters
// -----------------------------------------------------------------------------
package shift_register_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LATCH = 2'd3
  } sr_state_t;

  localparam int SR_NUM_BYTES    = 2;
  localparam int SR_CLK_DIV      = 4;
  localparam int SR_LATCH_CYCLES = 2;

  // Width of a down-counter that must hold values 0..n-1. A counter that
  // only ever holds 0 still needs one bit.
  function automatic int sr_cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

  function automatic int sr_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_half_period_timer.sv
// -----------------------------------------------------------------------------
// sr_half_period_timer
//   Loadable down-counter. Counts down to zero while enabled and stops there;
//   it never wraps. A load takes priority over counting, so the cycle that
//   sees the timer expire can reload it for the next phase.
//
//   Ports:
//     sysclk      in   clock, rising edge
//     reset       in   synchronous active-high reset, clears the count
//     load        in   load load_value on this edge
//     load_value  in   WIDTH  value to load
//     enable      in   count down (and qualify expired)
//     expired     out  count==0 while enabled
// -----------------------------------------------------------------------------
module sr_half_period_timer #(
  parameter int WIDTH = 2
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = enable && (count == '0);

endmodule

// File: rtl/shift_register_ctrl.sv
// -----------------------------------------------------------------------------
// shift_register_ctrl
//   Sequencer for a 74HC595-style serial-in/parallel-out chain. Accepts one
//   word, shifts it out MSB-first on sr_data with a divided clock sr_clk, then
//   pulses sr_latch so every chain output updates together.
//
//   Each bit occupies one SETUP phase (sr_clk low, data presented) followed by
//   one HIGH phase (sr_clk high, data held), each CLK_DIV sysclk cycles long.
//   A single down-counter times both half-periods and the latch hold, since
//   those phases never overlap.
//
//   Handshake: a word is accepted on a rising sysclk edge where
//   load_valid && load_ready. load_ready is high only in IDLE and outside
//   reset; load_valid outside IDLE is ignored (nothing is captured or queued)
//   and load_data is sampled only at the accept edge.
//
//   Ports:
//     sysclk      in   system clock, all logic on the rising edge
//     reset       in   synchronous active-high reset (aborts any transfer)
//     load_valid  in   load_data is valid
//     load_ready  out  controller idle and able to accept a word
//     load_data   in   8*NUM_BYTES  word to shift, top bit shifted first
//     sr_clk      out  shift clock to the chain (registered)
//     sr_data     out  serial data to the chain (registered)
//     sr_latch    out  storage-register latch pulse (registered)
//     busy        out  high from the accept edge until back in IDLE
//     done        out  one-cycle pulse as LATCH returns to IDLE
// -----------------------------------------------------------------------------
module shift_register_ctrl
  import shift_register_pkg::*;
#(
  parameter int NUM_BYTES    = SR_NUM_BYTES,
  parameter int CLK_DIV      = SR_CLK_DIV,
  parameter int LATCH_CYCLES = SR_LATCH_CYCLES
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [8*NUM_BYTES-1:0] load_data,
  output logic                   sr_clk,
  output logic                   sr_data,
  output logic                   sr_latch,
  output logic                   busy,
  output logic                   done
);

  localparam int N_BITS = 8 * NUM_BYTES;
  localparam int BW     = sr_cnt_width(N_BITS);
  localparam int HW     = sr_cnt_width(CLK_DIV);
  localparam int LW     = sr_cnt_width(LATCH_CYCLES);
  // The shared timer must hold the larger of the two reload values.
  localparam int TW     = sr_max(HW, LW);

  localparam logic [TW-1:0] HALF_RELOAD  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] LATCH_RELOAD = TW'(LATCH_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST     = BW'(N_BITS - 1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  sr_state_t         state;
  sr_state_t         state_d;
  logic [N_BITS-1:0] shifter;
  logic [N_BITS-1:0] shifter_d;
  logic [BW-1:0]     bit_cnt;
  logic [BW-1:0]     bit_cnt_d;

  logic sr_clk_d;
  logic sr_data_d;
  logic sr_latch_d;
  logic busy_d;
  logic done_d;

  logic          accept;
  logic          last_bit;
  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_enable;
  logic          tmr_expired;

  assign load_ready = (state == ST_IDLE) && !reset;
  assign accept     = load_valid && load_ready;
  assign last_bit   = (bit_cnt == '0);
  assign tmr_enable = (state != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Phase timer: half-period in SETUP/HIGH, latch hold in LATCH
  // ---------------------------------------------------------------------------
  sr_half_period_timer #(
    .WIDTH (TW)
  ) u_timer (
    .sysclk     (sysclk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .enable     (tmr_enable),
    .expired    (tmr_expired)
  );

  // ---------------------------------------------------------------------------
  // State register (also registers every output except load_ready)
  // ---------------------------------------------------------------------------
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state    <= ST_IDLE;
      shifter  <= '0;
      bit_cnt  <= '0;
      sr_clk   <= 1'b0;
      sr_data  <= 1'b0;
      sr_latch <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      shifter  <= shifter_d;
      bit_cnt  <= bit_cnt_d;
      sr_clk   <= sr_clk_d;
      sr_data  <= sr_data_d;
      sr_latch <= sr_latch_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_expired) begin
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (tmr_expired) begin
          state_d = last_bit ? ST_LATCH : ST_SETUP;
        end
      end
      ST_LATCH: begin
        if (tmr_expired) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic: next values of the registered outputs, shifter,
  // bit counter and timer reload.
  // ---------------------------------------------------------------------------
  always_comb begin
    shifter_d  = shifter;
    bit_cnt_d  = bit_cnt;
    sr_clk_d   = sr_clk;
    sr_data_d  = sr_data;
    sr_latch_d = sr_latch;
    busy_d     = busy;
    done_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_value  = HALF_RELOAD;

    case (state)
      ST_IDLE: begin
        sr_clk_d   = 1'b0;
        sr_data_d  = 1'b0;
        sr_latch_d = 1'b0;
        busy_d     = 1'b0;
        if (accept) begin
          shifter_d = load_data;
          bit_cnt_d = BIT_LAST;
          tmr_load  = 1'b1;
          // Present the first bit immediately so it is stable for the whole
          // SETUP phase ahead of the first sr_clk rise.
          sr_data_d = load_data[N_BITS-1];
          busy_d    = 1'b1;
        end
      end

      ST_SETUP: begin
        sr_clk_d  = 1'b0;
        sr_data_d = shifter[N_BITS-1];
        if (tmr_expired) begin
          sr_clk_d = 1'b1;
          tmr_load = 1'b1;
        end
      end

      ST_HIGH: begin
        // sr_data is left untouched so it holds through the high phase.
        if (tmr_expired) begin
          sr_clk_d = 1'b0;
          tmr_load = 1'b1;
          if (last_bit) begin
            sr_data_d  = 1'b0;
            sr_latch_d = 1'b1;
            tmr_value  = LATCH_RELOAD;
          end else begin
            shifter_d = {shifter[N_BITS-2:0], 1'b0};
            bit_cnt_d = bit_cnt - BW'(1);
            // The bit below the current MSB becomes the next MSB.
            sr_data_d = shifter[N_BITS-2];
          end
        end
      end

      ST_LATCH: begin
        if (tmr_expired) begin
          sr_latch_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end
      end

      default: begin
        sr_clk_d   = 1'b0;
        sr_data_d  = 1'b0;
        sr_latch_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_register_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_register_ctrl
//   Two instances: "a" with default geometry (2 bytes, CLK_DIV=4, LATCH=2)
//   and "b" with the minimum corner (1 byte, CLK_DIV=1, LATCH=1). Drivers push
//   the expected {bit, rise cycle} per shifted bit and the expected
//   {busy length, done cycle} per word; per-instance monitors pop and compare
//   whenever the DUT shows an sr_clk rise or a done pulse.
// -----------------------------------------------------------------------------
module tb_shift_register_ctrl;

  localparam int A_CD = 4;
  localparam int A_LC = 2;
  localparam int A_N  = 16;
  localparam int B_CD = 1;
  localparam int B_LC = 1;
  localparam int B_N  = 8;
  localparam int W    = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  int   cyc    = 0;

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  logic             load_valid_a = 1'b0;
  logic [A_N-1:0]   load_data_a  = '0;
  logic             load_ready_a, sr_clk_a, sr_data_a, sr_latch_a, busy_a, done_a;
  logic             load_valid_b = 1'b0;
  logic [B_N-1:0]   load_data_b  = '0;
  logic             load_ready_b, sr_clk_b, sr_data_b, sr_latch_b, busy_b, done_b;

  shift_register_ctrl u_dut_a (
    .sysclk     (sysclk),
    .reset      (reset),
    .load_valid (load_valid_a),
    .load_ready (load_ready_a),
    .load_data  (load_data_a),
    .sr_clk     (sr_clk_a),
    .sr_data    (sr_data_a),
    .sr_latch   (sr_latch_a),
    .busy       (busy_a),
    .done       (done_a)
  );

  shift_register_ctrl #(
    .NUM_BYTES    (1),
    .CLK_DIV      (B_CD),
    .LATCH_CYCLES (B_LC)
  ) u_dut_b (
    .sysclk     (sysclk),
    .reset      (reset),
    .load_valid (load_valid_b),
    .load_ready (load_ready_b),
    .load_data  (load_data_b),
    .sr_clk     (sr_clk_b),
    .sr_data    (sr_data_b),
    .sr_latch   (sr_latch_b),
    .busy       (busy_b),
    .done       (done_b)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  logic [63:0]  exp_done_q_a[$];
  logic [63:0]  exp_done_q_b[$];
  int          t0_a = 0;
  int          t0_b = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor a
  // ---------------------------------------------------------------------------
  logic prev_clk_a = 1'b0, prev_busy_a = 1'b0, held_a = 1'b0;
  int   busy_len_a = 0, latch_len_a = 0, rises_a = 0;
  int   latch_total_a = 0, done_total_a = 0;

  always @(negedge sysclk) begin
    logic [W-1:0] e;
    logic [63:0]  d;
    if (busy_a && !prev_busy_a) begin
      busy_len_a = 0; latch_len_a = 0; rises_a = 0;
    end
    if (busy_a) busy_len_a++;
    if (!busy_a) check("a_idle_outputs", {61'd0, sr_clk_a, sr_data_a, sr_latch_a}, 64'd0);
    if (sr_latch_a) begin
      latch_len_a++; latch_total_a++;
      check("a_latch_vs_clk", {63'd0, sr_clk_a}, 64'd0);
    end
    if (sr_clk_a && prev_clk_a) check("a_data_hold", {63'd0, sr_data_a}, {63'd0, held_a});
    if (sr_clk_a && !prev_clk_a) begin
      rises_a++;
      held_a = sr_data_a;
      check("a_rise_expected", 64'(exp_q_a.size() != 0), 64'd1);
      if (exp_q_a.size() != 0) begin
        e = exp_q_a.pop_front();
        check("a_rise_bit_cycle", {32'd0, sr_data_a, 31'(cyc)}, {32'd0, e});
      end
    end
    if (done_a) begin
      done_total_a++;
      check("a_done_expected", 64'(exp_done_q_a.size() != 0), 64'd1);
      if (exp_done_q_a.size() != 0) begin
        d = exp_done_q_a.pop_front();
        check("a_done_cycle", 64'(cyc), {32'd0, d[31:0]});
        check("a_busy_len", 64'(busy_len_a), {32'd0, d[63:32]});
        check("a_latch_len", 64'(latch_len_a), 64'(A_LC));
        check("a_rise_count", 64'(rises_a), 64'(A_N));
      end
    end
    prev_clk_a  = sr_clk_a;
    prev_busy_a = busy_a;
  end

  // ---------------------------------------------------------------------------
  // Monitor b
  // ---------------------------------------------------------------------------
  logic prev_clk_b = 1'b0, prev_busy_b = 1'b0, held_b = 1'b0;
  int   busy_len_b = 0, latch_len_b = 0, rises_b = 0;

  always @(negedge sysclk) begin
    logic [W-1:0] e;
    logic [63:0]  d;
    if (busy_b && !prev_busy_b) begin
      busy_len_b = 0; latch_len_b = 0; rises_b = 0;
    end
    if (busy_b) busy_len_b++;
    if (!busy_b) check("b_idle_outputs", {61'd0, sr_clk_b, sr_data_b, sr_latch_b}, 64'd0);
    if (sr_latch_b) begin
      latch_len_b++;
      check("b_latch_vs_clk", {63'd0, sr_clk_b}, 64'd0);
    end
    if (sr_clk_b && prev_clk_b) check("b_data_hold", {63'd0, sr_data_b}, {63'd0, held_b});
    if (sr_clk_b && !prev_clk_b) begin
      rises_b++;
      held_b = sr_data_b;
      check("b_rise_expected", 64'(exp_q_b.size() != 0), 64'd1);
      if (exp_q_b.size() != 0) begin
        e = exp_q_b.pop_front();
        check("b_rise_bit_cycle", {32'd0, sr_data_b, 31'(cyc)}, {32'd0, e});
      end
    end
    if (done_b) begin
      check("b_done_expected", 64'(exp_done_q_b.size() != 0), 64'd1);
      if (exp_done_q_b.size() != 0) begin
        d = exp_done_q_b.pop_front();
        check("b_done_cycle", 64'(cyc), {32'd0, d[31:0]});
        check("b_busy_len", 64'(busy_len_b), {32'd0, d[63:32]});
        check("b_latch_len", 64'(latch_len_b), 64'(B_LC));
        check("b_rise_count", 64'(rises_b), 64'(B_N));
      end
    end
    prev_clk_b  = sr_clk_b;
    prev_busy_b = busy_b;
  end

  // ---------------------------------------------------------------------------
  // Drivers (called at a negedge; return one negedge after the accept edge)
  // Cycle 0 is the cycle whose closing edge accepts the word: first sr_clk
  // rise at cycle CLK_DIV+1, one rise per 2*CLK_DIV, done at busy length + 1.
  // ---------------------------------------------------------------------------
  task automatic send_a(input logic [A_N-1:0] d, input bit on_done);
    int n = 0;
    load_valid_a = 1'b1;
    load_data_a  = d;
    while (!load_ready_a && n < 400) begin
      @(negedge sysclk);
      n++;
    end
    check("a_accept_timeout", {63'd0, load_ready_a}, 64'd1);
    if (load_ready_a) begin
      t0_a = cyc;
      if (on_done) check("a_accept_on_done", {63'd0, done_a}, 64'd1);
      for (int i = 0; i < A_N; i++)
        exp_q_a.push_back({d[A_N-1-i], 31'(t0_a + A_CD + 1 + 2*A_CD*i)});
      exp_done_q_a.push_back({32'(2*A_CD*A_N + A_LC), 32'(t0_a + 2*A_CD*A_N + A_LC + 1)});
    end
    @(negedge sysclk);
    load_valid_a = 1'b0;
    load_data_a  = ~d;
  endtask

  task automatic send_b(input logic [B_N-1:0] d);
    int n = 0;
    load_valid_b = 1'b1;
    load_data_b  = d;
    while (!load_ready_b && n < 400) begin
      @(negedge sysclk);
      n++;
    end
    check("b_accept_timeout", {63'd0, load_ready_b}, 64'd1);
    if (load_ready_b) begin
      t0_b = cyc;
      for (int i = 0; i < B_N; i++)
        exp_q_b.push_back({d[B_N-1-i], 31'(t0_b + B_CD + 1 + 2*B_CD*i)});
      exp_done_q_b.push_back({32'(2*B_CD*B_N + B_LC), 32'(t0_b + 2*B_CD*B_N + B_LC + 1)});
    end
    @(negedge sysclk);
    load_valid_b = 1'b0;
    load_data_b  = ~d;
  endtask

  task automatic wait_done_a(input string name);
    int n = 0;
    while (!done_a && n < 400) begin
      @(negedge sysclk);
      n++;
    end
    check(name, {63'd0, done_a}, 64'd1);
  endtask

  task automatic wait_done_b(input string name);
    int n = 0;
    while (!done_b && n < 100) begin
      @(negedge sysclk);
      n++;
    end
    check(name, {63'd0, done_b}, 64'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int  n;
    int  lt;
    int  dt;
    logic bad;

    // Reset held for 3 cycles, then released.
    reset = 1'b1;
    repeat (3) begin
      @(negedge sysclk);
      check("reset_outputs_a", {58'd0, busy_a, done_a, sr_clk_a, sr_data_a, sr_latch_a, load_ready_a}, 64'd0);
      check("reset_outputs_b", {58'd0, busy_b, done_b, sr_clk_b, sr_data_b, sr_latch_b, load_ready_b}, 64'd0);
    end
    reset = 1'b0;
    @(negedge sysclk);
    check("ready_after_release_a", {63'd0, load_ready_a}, 64'd1);
    check("ready_after_release_b", {63'd0, load_ready_b}, 64'd1);

    // Single word, default geometry: 1010_0101_1100_0011.
    send_a(16'hA5C3, 1'b0);
    wait_done_a("a5c3_done");

    // Back-to-back with load_valid held: second accept lands on the done cycle.
    send_a(16'hFFFF, 1'b0);
    send_a(16'h0001, 1'b1);
    wait_done_a("b2b_done");

    // A load attempt in the middle of a transfer is ignored.
    send_a(16'h0F0F, 1'b0);
    while (cyc < t0_a + 40) @(negedge sysclk);
    load_valid_a = 1'b1;
    load_data_a  = 16'h1234;
    check("busy_ready_low", {63'd0, load_ready_a}, 64'd0);
    @(negedge sysclk);
    load_valid_a = 1'b0;
    bad = 1'b0;
    n   = 0;
    while (!done_a && n < 400) begin
      bad |= load_ready_a;
      @(negedge sysclk);
      n++;
    end
    check("ignore_done", {63'd0, done_a}, 64'd1);
    check("ready_low_until_done", {63'd0, bad}, 64'd0);

    // Reset in the middle of a shift aborts without latch or done.
    @(negedge sysclk);
    send_a(16'hABCD, 1'b0);
    while (cyc < t0_a + 60) @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);
    check("abort_outputs", {58'd0, sr_clk_a, sr_data_a, sr_latch_a, busy_a, done_a, load_ready_a}, 64'd0);
    // Rises at 5,13,...,53 have been consumed; the remaining 9 never happen.
    check("abort_bits_pending", 64'(exp_q_a.size()), 64'd9);
    exp_q_a.delete();
    exp_done_q_a.delete();
    lt = latch_total_a;
    dt = done_total_a;
    @(negedge sysclk);
    reset = 1'b0;
    repeat (150) @(negedge sysclk);
    check("abort_no_latch", 64'(latch_total_a), 64'(lt));
    check("abort_no_done", 64'(done_total_a), 64'(dt));

    // Corner geometry: sr_clk = sysclk/2, single-cycle latch, busy 17.
    send_b(8'h81);
    wait_done_b("b81_done");
    send_b(8'h5A);
    wait_done_b("b5a_done");

    repeat (5) @(negedge sysclk);
    check("a_queues_empty", 64'(exp_q_a.size() + exp_done_q_a.size()), 64'd0);
    check("b_queues_empty", 64'(exp_q_b.size() + exp_done_q_b.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
